// File: rtl/alarm_ctrl.sv
// alarm_ctrl: time-of-day keeper, set-mode sequencer and alarm/snooze ringer.
// Optional snooze support is built when SNOOZE_EN is defined.
module alarm_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic [4:0] al_hh,
    output logic [5:0] al_mm,
    output logic [2:0] mode,
    output logic       armed,
    output logic       ringing
);

    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_SET_HH   = 3'd1;
    localparam logic [2:0] S_SET_MM   = 3'd2;
    localparam logic [2:0] S_SET_AL_HH = 3'd3;
    localparam logic [2:0] S_SET_AL_MM = 3'd4;

    localparam logic [7:0] RING_N = 8'(RING_SEC);

    logic [2:0] state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [4:0] hh_q, hh_d, al_hh_q, al_hh_d;
    logic [5:0] mm_q, mm_d, ss_q, ss_d, al_mm_q, al_mm_d;
    logic       armed_q, armed_d;
    logic       ring_q, ring_d;
    logic [7:0] cnt_q, cnt_d;
    logic       chk_q, chk_d;
    logic       run_st;
    logic       al_hit;

`ifdef SNOOZE_EN
    localparam logic [6:0] SNZ = 7'(SNOOZE_MIN);
    logic       pend_q, pend_d;
    logic [4:0] tgt_hh_q, tgt_hh_d;
    logic [5:0] tgt_mm_q, tgt_mm_d;
    logic [6:0] msum;
    logic       snz_hit;
`else
    logic       unused_snooze_min;
    assign unused_snooze_min = ^7'(SNOOZE_MIN);
`endif

    assign hh      = hh_q;
    assign mm      = mm_q;
    assign ss      = ss_q;
    assign al_hh   = al_hh_q;
    assign al_mm   = al_mm_q;
    assign mode    = mode_q;
    assign armed   = armed_q;
    assign ringing = ring_q;

    // Next-state logic: timekeeping, ringing, trigger, buttons, mode sequencing.
    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        armed_d = armed_q;
        ring_d  = ring_q;
        cnt_d   = cnt_q;
        chk_d   = 1'b0;
        mode_d  = 3'b000;
        run_st  = (state_q == S_RUN) || (state_q == S_SET_AL_HH) ||
                  (state_q == S_SET_AL_MM);
        al_hit  = (hh_q == al_hh_q) && (mm_q == al_mm_q);
`ifdef SNOOZE_EN
        pend_d   = pend_q;
        tgt_hh_d = tgt_hh_q;
        tgt_mm_d = tgt_mm_q;
        msum     = {1'b0, mm_q} + SNZ;
        snz_hit  = pend_q && (hh_q == tgt_hh_q) && (mm_q == tgt_mm_q);
`endif

        if (tick && run_st) begin
            if (ss_q == 6'd59) begin
                ss_d  = 6'd0;
                chk_d = 1'b1;
                if (mm_q == 6'd59) begin
                    mm_d = 6'd0;
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end

        if (ring_q) begin
            if (tick) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == RING_N) ring_d = 1'b0;
            end
            if (btn_mode) ring_d = 1'b0;
            if (btn_snooze) begin
                ring_d = 1'b0;
`ifdef SNOOZE_EN
                pend_d = 1'b1;
                if (msum >= 7'd60) begin
                    tgt_mm_d = 6'(msum - 7'd60);
                    tgt_hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                end else begin
                    tgt_mm_d = msum[5:0];
                    tgt_hh_d = hh_q;
                end
`endif
            end
        end

`ifdef SNOOZE_EN
        if (chk_q && run_st && armed_q && (al_hit || snz_hit)) begin
            ring_d = 1'b1;
            cnt_d  = 8'd0;
            if (snz_hit) pend_d = 1'b0;
        end
`else
        if (chk_q && run_st && armed_q && al_hit) begin
            ring_d = 1'b1;
            cnt_d  = 8'd0;
        end
`endif

        if (btn_inc) begin
            unique case (state_q)
                S_RUN: begin
                    armed_d = ~armed_q;
                    if (armed_q) begin
                        ring_d = 1'b0;
`ifdef SNOOZE_EN
                        pend_d = 1'b0;
`endif
                    end
                end
                S_SET_HH:
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                S_SET_MM:
                    mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
                S_SET_AL_HH:
                    al_hh_d = (al_hh_q == 5'd23) ? 5'd0 : al_hh_q + 5'd1;
                S_SET_AL_MM:
                    al_mm_d = (al_mm_q == 6'd59) ? 6'd0 : al_mm_q + 6'd1;
                default: ;
            endcase
        end

        // A mode press during ringing only dismisses; it never steps the FSM.
        if (btn_mode && !ring_q) begin
            unique case (state_q)
                S_RUN: begin
                    state_d = S_SET_HH;
                    ss_d    = 6'd0;
                end
                S_SET_HH:    state_d = S_SET_MM;
                S_SET_MM:    state_d = S_SET_AL_HH;
                S_SET_AL_HH: state_d = S_SET_AL_MM;
                default:     state_d = S_RUN;
            endcase
        end

        unique case (state_d)
            S_SET_HH:                 mode_d = 3'b001;
            S_SET_MM:                 mode_d = 3'b010;
            S_SET_AL_HH, S_SET_AL_MM: mode_d = 3'b100;
            default:                  mode_d = 3'b000;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            mode_q  <= 3'b000;
            hh_q    <= 5'd0;
            mm_q    <= 6'd0;
            ss_q    <= 6'd0;
            al_hh_q <= 5'd6;
            al_mm_q <= 6'd0;
            armed_q <= 1'b0;
            ring_q  <= 1'b0;
            cnt_q   <= 8'd0;
            chk_q   <= 1'b0;
`ifdef SNOOZE_EN
            pend_q   <= 1'b0;
            tgt_hh_q <= 5'd0;
            tgt_mm_q <= 6'd0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            al_hh_q <= al_hh_d;
            al_mm_q <= al_mm_d;
            armed_q <= armed_d;
            ring_q  <= ring_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
`ifdef SNOOZE_EN
            pend_q   <= pend_d;
            tgt_hh_q <= tgt_hh_d;
            tgt_mm_q <= tgt_mm_d;
`endif
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed stimulus with a queued expected-state scoreboard.
// Expected snapshots are compared on the falling edge after each push.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, btn_mode, btn_inc, btn_snooze;
  logic [4:0] hh, al_hh;
  logic [5:0] mm, ss, al_mm;
  logic [2:0] mode;
  logic       armed, ringing;

  alarm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_snooze (btn_snooze),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .al_hh      (al_hh),
    .al_mm      (al_mm),
    .mode       (mode),
    .armed      (armed),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [4:0] al_hh;
    logic [5:0] al_mm;
    logic [2:0] mode;
    logic       armed;
    logic       ringing;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic expect_s(input string nm, input int h, input int m,
                          input int s, input int ah, input int am,
                          input logic [2:0] md, input logic ar,
                          input logic rg);
    snap_t e;
    e.hh      = 5'(h);
    e.mm      = 6'(m);
    e.ss      = 6'(s);
    e.al_hh   = 5'(ah);
    e.al_mm   = 6'(am);
    e.mode    = md;
    e.armed   = ar;
    e.ringing = rg;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : mon
    snap_t e, a;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hh, mm, ss, al_hh, al_mm, mode, armed, ringing};
      n_chk++;
      if (a === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %0d:%0d:%0d al=%0d:%0d mode=%b armed=%b ring=%b, want %0d:%0d:%0d al=%0d:%0d mode=%b armed=%b ring=%b",
                 nm, a.hh, a.mm, a.ss, a.al_hh, a.al_mm, a.mode,
                 a.armed, a.ringing, e.hh, e.mm, e.ss, e.al_hh,
                 e.al_mm, e.mode, e.armed, e.ringing);
      end
    end
  end

  task automatic cyc(input logic t, input logic m, input logic i,
                     input logic s);
    @(negedge clk);
    tick       = t;
    btn_mode   = m;
    btn_inc    = i;
    btn_snooze = s;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    btn_mode   = 1'b0;
    btn_inc    = 1'b0;
    btn_snooze = 1'b0;
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic inc(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic md(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; btn_mode = 1'b0;
    btn_inc = 1'b0; btn_snooze = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_s("reset", 0, 0, 0, 6, 0, 3'b000, 0, 0);

    md(1); inc(23);
    expect_s("set_hh", 23, 0, 0, 6, 0, 3'b001, 0, 0);
    md(1); inc(59);
    expect_s("set_mm", 23, 59, 0, 6, 0, 3'b010, 0, 0);
    md(3);
    expect_s("back_run", 23, 59, 0, 6, 0, 3'b000, 0, 0);
    tk(58);
    expect_s("pre_wrap", 23, 59, 58, 6, 0, 3'b000, 0, 0);
    tk(2);
    expect_s("wrap", 0, 0, 0, 6, 0, 3'b000, 0, 0);

    tk(37);
    expect_s("ss37", 0, 0, 37, 6, 0, 3'b000, 0, 0);
    md(1);
    expect_s("enter_set_clr", 0, 0, 0, 6, 0, 3'b001, 0, 0);
    tk(10);
    expect_s("frozen", 0, 0, 0, 6, 0, 3'b001, 0, 0);
    inc(25);
    expect_s("hh_wrap_inc", 1, 0, 0, 6, 0, 3'b001, 0, 0);
    md(4);
    expect_s("run_again", 1, 0, 0, 6, 0, 3'b000, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    expect_s("tick_mode_clr", 1, 0, 0, 6, 0, 3'b001, 0, 0);

    inc(4); md(1); inc(59);
    expect_s("set_0559", 5, 59, 0, 6, 0, 3'b010, 0, 0);
    md(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    expect_s("tick_inc_al", 5, 59, 1, 7, 0, 3'b100, 0, 0);
    inc(23);
    expect_s("al_hh_wrap", 5, 59, 1, 6, 0, 3'b100, 0, 0);
    md(2); tk(58);
    expect_s("pre_alarm", 5, 59, 59, 6, 0, 3'b000, 0, 0);
    inc(1);
    expect_s("arm", 5, 59, 59, 6, 0, 3'b000, 1, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_s("tick_edge", 6, 0, 0, 6, 0, 3'b000, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_s("ring_rise", 6, 0, 0, 6, 0, 3'b000, 1, 1);
    tk(59);
    expect_s("ring_hold", 6, 0, 59, 6, 0, 3'b000, 1, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_s("ring_expire", 6, 1, 0, 6, 0, 3'b000, 1, 0);

    md(4); inc(2); md(1);
    expect_s("al_0602", 6, 1, 0, 6, 2, 3'b000, 1, 0);
    tk(60);
    expect_s("ring2", 6, 2, 0, 6, 2, 3'b000, 1, 1);
    md(1);
    expect_s("mode_dismiss", 6, 2, 0, 6, 2, 3'b000, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_s("mode_consumed", 6, 2, 0, 6, 2, 3'b000, 1, 0);
    inc(1);
    expect_s("disarm", 6, 2, 0, 6, 2, 3'b000, 0, 0);
    md(4); inc(1); md(1);
    expect_s("al_0603", 6, 2, 0, 6, 3, 3'b000, 0, 0);
    tk(60);
    expect_s("disarmed_pass", 6, 3, 0, 6, 3, 3'b000, 0, 0);

    md(1); inc(17); md(1); inc(54);
    md(1); inc(17); md(1); inc(55); md(1);
    expect_s("setup_2357", 23, 57, 0, 23, 58, 3'b000, 0, 0);
    inc(1); tk(60);
    expect_s("ring_2358", 23, 58, 0, 23, 58, 3'b000, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_s("snooze_btn", 23, 58, 0, 23, 58, 3'b000, 1, 0);
`ifdef SNOOZE_EN
    tk(299);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_s("snz_tick", 0, 3, 0, 23, 58, 3'b000, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_s("snz_ring", 0, 3, 0, 23, 58, 3'b000, 1, 1);
    md(1);
    expect_s("snz_dismiss", 0, 3, 0, 23, 58, 3'b000, 1, 0);
`else
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_s("snooze_idle", 23, 58, 0, 23, 58, 3'b000, 1, 0);
    tk(300);
    expect_s("no_snooze", 0, 3, 0, 23, 58, 3'b000, 1, 0);
`endif

    md(3); inc(1); md(1); inc(6);
    expect_s("al_0004", 0, 3, 0, 0, 4, 3'b100, 1, 0);
    tk(60);
    expect_s("ring_setal", 0, 4, 0, 0, 4, 3'b100, 1, 1);
    @(negedge clk);
    rst = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; tick = 1'b0;
    expect_s("rst_mid", 0, 0, 0, 6, 0, 3'b000, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_s("rst_hold", 0, 0, 0, 6, 0, 3'b000, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    if ((n_chk > 0) && (n_pass == n_chk))
      $display("PASS");
    else
      $display("FAIL summary: %0d of %0d checks failed",
               n_chk - n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Time-of-day and alarm controller for the alarm clock. It consumes the single-cycle tick produced by the clock divider and keeps hours, minutes and seconds. It sequences the user set modes from three debounced push-button pulses and raises a ringing output when the armed alarm time, or a pending snooze time, is reached. It sits between the clock divider and the display/buzzer drivers.

## Interface
Parameters:
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.
- RING_SEC, 60: ringing auto-stops after this many ticks, 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the clock divider; one per second.
- btn_mode  in  1  one-cycle debounced pulse.
- btn_inc  in  1  one-cycle debounced pulse.
- btn_snooze  in  1  one-cycle debounced pulse.
- hh  out  5  current hours, 0..23.
- mm  out  6  current minutes, 0..59.
- ss  out  6  current seconds, 0..59.
- al_hh  out  5  alarm hours.
- al_mm  out  6  alarm minutes.
- mode  out  3  one-hot set-mode indication for the display: {AL, MM, HH}. All zero in RUN; in SET_AL_HH and SET_AL_MM only the AL bit is set.
- armed  out  1  alarm enabled.
- ringing  out  1  buzzer request.

## Operation
- All outputs are registered. Reset values: time 00:00:00, alarm 06:00, mode RUN, armed 0, ringing 0, snooze pending 0, ring counter 0.
- FSM states: RUN → SET_HH → SET_MM → SET_AL_HH → SET_AL_MM → RUN. The state advances one step on each btn_mode, except while ringing (see below).
- Timekeeping:
  - Advances on tick in RUN, SET_AL_HH and SET_AL_MM.
  - ss wraps 59→0 with a carry to mm; mm wraps 59→0 with a carry to hh; hh wraps 23→0.
  - Frozen in SET_HH and SET_MM.
  - Entering SET_HH clears ss to 0.
- btn_inc, by state:
  - SET_HH: hh+1, wrapping 23→0, no carry.
  - SET_MM: mm+1, wrapping 59→0, no carry into hh.
  - SET_AL_HH: al_hh+1, wrapping 23→0.
  - SET_AL_MM: al_mm+1, wrapping 59→0.
  - RUN: toggles armed. Disarming also clears ringing and snooze pending.
- Trigger:
  - Evaluated only in the cycle after a tick left ss==0, in a time-running state, with armed=1.
  - Match condition: {hh,mm} equals {al_hh,al_mm}, or snooze pending is set and {hh,mm} equals the snooze target.
  - On a match, ringing sets and the ring counter loads 0.
  - A snooze match clears snooze pending.
- While ringing:
  - Each tick increments the ring counter. On reaching RING_SEC, ringing clears (dismiss).
  - btn_snooze: ringing clears; snooze target = current {hh,mm} + SNOOZE_MIN minutes, modulo 24 h; snooze pending sets.
  - btn_mode: ringing clears (dismiss) and the state does not change; the pulse is consumed.
- A new alarm match while snooze is pending re-triggers normally and keeps the snooze target.

## Timing
- Time registers update on the clk edge where tick=1.
- ringing rises exactly 2 edges after the tick that produced ss=0: one edge for the time update, one for the registered compare.
- Button effects are visible on the edge the pulse is sampled. mode changes 1 cycle after btn_mode.
- Simultaneous events:
  - tick + btn_inc in a SET_AL state: both apply.
  - tick + btn_mode in RUN: the time advances and the state moves to SET_HH, with ss cleared; the clear wins over the tick.
  - btn_snooze + ring-counter expiry in the same cycle: snooze wins.
  - btn_snooze when not ringing: ignored.
- rst in any state, including mid-ring or mid-set, restores all reset values on the next edge.
- Width rules: the snooze addition uses a 7-bit minute sum. If the sum is ≥60, subtract 60 and carry 1 hour; hours wrap 23→0.

## Configuration
- SNOOZE_EN defined: snooze behaves as described.
- SNOOZE_EN undefined:
  - btn_snooze acts as a dismiss only.
  - The snooze target and pending registers are not built.
  - The trigger compares the alarm time only.
  - SNOOZE_MIN is unused.

## Test plan
- Wrap: set time to 23:59:58 in SET_HH/SET_MM, return to RUN, apply 2 ticks → 00:00:00; hh, mm and ss all wrap.
- Set-mode freeze: enter SET_HH at ss=37 → ss=0; 10 ticks → time unchanged; 25 btn_inc → hh = 1 (wrapped past 23).
- Alarm: alarm 06:00, armed, time 05:59:59, one tick → ringing=1 exactly 2 edges after the tick; no further input → ringing=0 after 60 ticks.
- Snooze (SNOOZE_EN): ringing at 23:58, btn_snooze → ringing=0; ringing rises again at 00:03:00, then pending=0.
- Dismiss/disarm: while ringing, btn_mode → ringing=0 and mode stays RUN; btn_inc in RUN → armed=0; the alarm time passes → ringing stays 0.
- Reset mid-ring in SET_AL_MM → all outputs at reset values next edge; a tick on the same edge as rst is ignored.
